arf_sched_ctrl: RTL

ARF_SCHED_CTRL -- requirements
Module: arf_sched_ctrl

---
 rtl/arf_pkg.sv | 52 +++++
 rtl/arf_sched_ctrl_if.sv | 25 ++
 rtl/arf_step_rom.sv | 46 ++++
 rtl/arf_sched_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
// -----------------------------------------------------------------------------
// arf_pkg
// Shared definitions for the ARF variance scheduler: controller state enum,
// operation identifiers (numbered to match the 28-op DFG), step count, datapath
// widths and the arithmetic helpers used by the shared functional units.
// -----------------------------------------------------------------------------
package arf_pkg;

    localparam int W16 = 16;
    localparam int W32 = 32;
    localparam int W64 = 64;

    // Number of schedule steps executed in RUN (steps 0..STEP_COUNT-1).
    localparam int STEP_COUNT = 13;
    localparam logic [3:0] LAST_STEP = 4'(STEP_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encoding equals the op number so an op id doubles as its result slot.
    typedef enum logic [4:0] {
        OP_NONE = 5'd0,
        OP_M1   = 5'd1,  OP_M2  = 5'd2,  OP_M3  = 5'd3,  OP_M4  = 5'd4,
        OP_M5   = 5'd5,  OP_M6  = 5'd6,  OP_M7  = 5'd7,  OP_M8  = 5'd8,
        OP_A9   = 5'd9,  OP_A10 = 5'd10, OP_A11 = 5'd11, OP_A12 = 5'd12,
        OP_A13  = 5'd13, OP_A14 = 5'd14,
        OP_M15  = 5'd15, OP_M16 = 5'd16, OP_M17 = 5'd17, OP_M18 = 5'd18,
        OP_A19  = 5'd19, OP_A20 = 5'd20,
        OP_M21  = 5'd21, OP_M22 = 5'd22, OP_M23 = 5'd23, OP_M24 = 5'd24,
        OP_A25  = 5'd25, OP_A26 = 5'd26, OP_A27 = 5'd27, OP_A28 = 5'd28
    } op_e;

    // Products enter the adder with the upper word replicated from bit 15,
    // not bit 31; the DFG treats a product as a 16-bit-signed quantity.
    function automatic logic [W64-1:0] prod_ext(input logic [W32-1:0] p);
        return {{32{p[15]}}, p};
    endfunction

    // Signed 16x16 multiply keeping the low 32 bits of the product.
    function automatic logic [W32-1:0] mul16(input logic [W16-1:0] a,
                                             input logic [W16-1:0] b);
        logic [W32-1:0] ax;
        logic [W32-1:0] bx;
        ax = {{16{a[15]}}, a};
        bx = {{16{b[15]}}, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/arf_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// arf_sched_ctrl_if
// Request/result bundle of the ARF scheduler.
//   start   : request one evaluation (master -> slave)
//   in_vec  : eight packed 16-bit inputs, in_k at [16k-1:16k-16]
//   busy    : evaluation in progress
//   done    : one-cycle pulse when out_27/out_28 become valid
//   out_27  : first ARF variance result
//   out_28  : second ARF variance result
// -----------------------------------------------------------------------------
interface arf_sched_ctrl_if;
    import arf_pkg::*;

    logic               start;
    logic [8*W16-1:0]   in_vec;
    logic               busy;
    logic               done;
    logic [W64-1:0]     out_27;
    logic [W64-1:0]     out_28;

    modport master (output start, output in_vec,
                    input  busy,  input  done, input out_27, input out_28);
    modport slave  (input  start, input  in_vec,
                    output busy,  output done, output out_27, output out_28);
endinterface

// File: rtl/arf_step_rom.sv
// -----------------------------------------------------------------------------
// arf_step_rom
// Combinational schedule table: maps the current step to the op issued on
// multiplier M0, multiplier M1 and adder A. OP_NONE means the unit is idle.
//   step  : schedule step 0..12
//   m0_op : op issued on M0
//   m1_op : op issued on M1
//   a_op  : op issued on A
// -----------------------------------------------------------------------------
module arf_step_rom
    import arf_pkg::*;
(
    input  logic [3:0] step,
    output op_e        m0_op,
    output op_e        m1_op,
    output op_e        a_op
);

    // Step decode; producers always sit at least one step ahead of consumers.
    always_comb begin
        m0_op = OP_NONE;
        m1_op = OP_NONE;
        a_op  = OP_NONE;
        case (step)
            4'd0:  begin m0_op = OP_M3;  m1_op = OP_M4;                    end
            4'd1:  begin m0_op = OP_M5;  m1_op = OP_M6;  a_op = OP_A10;    end
            4'd2:  begin m0_op = OP_M1;  m1_op = OP_M2;  a_op = OP_A13;    end
            4'd3:  begin m0_op = OP_M15; m1_op = OP_M17; a_op = OP_A11;    end
            4'd4:  begin m0_op = OP_M7;  m1_op = OP_M8;  a_op = OP_A14;    end
            4'd5:  begin m0_op = OP_M16; m1_op = OP_M18; a_op = OP_A9;     end
            4'd6:  begin                                 a_op = OP_A19;    end
            4'd7:  begin m0_op = OP_M21; m1_op = OP_M23; a_op = OP_A20;    end
            4'd8:  begin m0_op = OP_M22; m1_op = OP_M24; a_op = OP_A12;    end
            4'd9:  begin                                 a_op = OP_A25;    end
            4'd10: begin                                 a_op = OP_A26;    end
            4'd11: begin                                 a_op = OP_A27;    end
            4'd12: begin                                 a_op = OP_A28;    end
            default: begin
                m0_op = OP_NONE;
                m1_op = OP_NONE;
                a_op  = OP_NONE;
            end
        endcase
    end

endmodule

// File: rtl/arf_sched_ctrl.sv
// -----------------------------------------------------------------------------
// arf_sched_ctrl
// Evaluates the 28-op ARF variance DFG on two shared 16x16 multipliers and one
// shared 64-bit adder following a fixed 13-step schedule.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : arf_sched_ctrl_if.slave (start/in_vec in, busy/done/out_27/out_28 out)
// Parameters: C13/C14 constant right operands of a13/a14; KMUL multiplier
// coefficient (ops 21-23 use -KMUL).
// -----------------------------------------------------------------------------
module arf_sched_ctrl
    import arf_pkg::*;
#(
    parameter logic [W64-1:0] C13  = 64'd0,
    parameter logic [W64-1:0] C14  = 64'd0,
    parameter logic [W16-1:0] KMUL = 16'd3
)(
    input  logic               clk,
    input  logic               rst,
    arf_sched_ctrl_if.slave    bus
);

    localparam logic [W16-1:0] KNEG = 16'd0 - KMUL;

    state_e             state_r;
    state_e             state_s;
    logic [3:0]         step_r;
    logic [3:0]         step_s;
    logic               capture_s;
    logic               run_s;
    logic               finish_s;

    logic [8*W16-1:0]   in_r;
    logic [W64-1:0]     val_r [1:28];

    op_e                m0_op_s;
    op_e                m1_op_s;
    op_e                a_op_s;
    logic [W16-1:0]     m0_a_s;
    logic [W16-1:0]     m1_a_s;
    logic [W32-1:0]     m0_res_s;
    logic [W32-1:0]     m1_res_s;
    logic [W64-1:0]     add_x_s;
    logic [W64-1:0]     add_y_s;
    logic [W64-1:0]     a_res_s;

    logic               busy_r;
    logic               done_r;
    logic [W64-1:0]     out_27_r;
    logic [W64-1:0]     out_28_r;

    // Left multiplier operand for an op: captured input or low half of a sum.
    function automatic logic [W16-1:0] mul_src(input op_e op,
                                               input logic [8*W16-1:0] iv,
                                               input logic [W16-1:0] a13,
                                               input logic [W16-1:0] a14,
                                               input logic [W16-1:0] a19,
                                               input logic [W16-1:0] a20);
        case (op)
            OP_M1:          return iv[15:0];
            OP_M2:          return iv[31:16];
            OP_M3:          return iv[47:32];
            OP_M4:          return iv[63:48];
            OP_M5:          return iv[79:64];
            OP_M6:          return iv[95:80];
            OP_M7:          return iv[111:96];
            OP_M8:          return iv[127:112];
            OP_M15, OP_M17: return a13;
            OP_M16, OP_M18: return a14;
            OP_M21, OP_M23: return a19;
            OP_M22, OP_M24: return a20;
            default:        return 16'd0;
        endcase
    endfunction

    // Coefficient for an op: the negated KMUL feeds ops 21-23 only.
    function automatic logic [W16-1:0] mul_coef(input op_e op);
        case (op)
            OP_M21, OP_M22, OP_M23: return KNEG;
            default:                return KMUL;
        endcase
    endfunction

    arf_step_rom u_step_rom (
        .step  (step_r),
        .m0_op (m0_op_s),
        .m1_op (m1_op_s),
        .a_op  (a_op_s)
    );

    assign m0_a_s   = mul_src(m0_op_s, in_r, val_r[13][15:0], val_r[14][15:0],
                              val_r[19][15:0], val_r[20][15:0]);
    assign m1_a_s   = mul_src(m1_op_s, in_r, val_r[13][15:0], val_r[14][15:0],
                              val_r[19][15:0], val_r[20][15:0]);
    assign m0_res_s = mul16(m0_a_s, mul_coef(m0_op_s));
    assign m1_res_s = mul16(m1_a_s, mul_coef(m1_op_s));
    assign a_res_s  = add_x_s + add_y_s;

    // Adder operand select; products are widened with bit-15 replication.
    always_comb begin
        add_x_s = 64'd0;
        add_y_s = 64'd0;
        case (a_op_s)
            OP_A9:  begin add_x_s = prod_ext(val_r[1][31:0]);  add_y_s = prod_ext(val_r[2][31:0]);  end
            OP_A10: begin add_x_s = prod_ext(val_r[3][31:0]);  add_y_s = prod_ext(val_r[4][31:0]);  end
            OP_A11: begin add_x_s = prod_ext(val_r[5][31:0]);  add_y_s = prod_ext(val_r[6][31:0]);  end
            OP_A12: begin add_x_s = prod_ext(val_r[7][31:0]);  add_y_s = prod_ext(val_r[8][31:0]);  end
            OP_A13: begin add_x_s = val_r[10];                 add_y_s = C13;                       end
            OP_A14: begin add_x_s = val_r[11];                 add_y_s = C14;                       end
            OP_A19: begin add_x_s = prod_ext(val_r[15][31:0]); add_y_s = prod_ext(val_r[16][31:0]); end
            OP_A20: begin add_x_s = prod_ext(val_r[17][31:0]); add_y_s = prod_ext(val_r[18][31:0]); end
            OP_A25: begin add_x_s = prod_ext(val_r[21][31:0]); add_y_s = prod_ext(val_r[22][31:0]); end
            OP_A26: begin add_x_s = prod_ext(val_r[23][31:0]); add_y_s = prod_ext(val_r[24][31:0]); end
            OP_A27: begin add_x_s = val_r[9];                  add_y_s = val_r[25];                 end
            OP_A28: begin add_x_s = val_r[12];                 add_y_s = val_r[26];                 end
            default: begin
                add_x_s = 64'd0;
                add_y_s = 64'd0;
            end
        endcase
    end

    // Next-state and step sequencing for IDLE -> RUN(0..12) -> DONE -> IDLE.
    always_comb begin
        state_s   = state_r;
        step_s    = step_r;
        capture_s = 1'b0;
        run_s     = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                step_s = 4'd0;
                if (bus.start) begin
                    state_s   = ST_RUN;
                    capture_s = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                run_s = 1'b1;
                if (step_r == LAST_STEP) begin
                    state_s  = ST_DONE;
                    step_s   = 4'd0;
                    finish_s = 1'b1;
                end else begin
                    step_s   = step_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                step_s  = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                step_s  = 4'd0;
            end
        endcase
    end

    // State and step registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            step_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
        end
    end

    // Input capture at acceptance so later in_vec changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_r <= 128'd0;
        end else if (capture_s) begin
            in_r <= bus.in_vec;
        end
    end

    // Result slots: each unit writes the slot named by its op id this step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 28; i++) begin
                val_r[i] <= 64'd0;
            end
        end else if (run_s) begin
            for (int i = 1; i <= 28; i++) begin
                if (5'(i) == m0_op_s) begin
                    val_r[i] <= {32'd0, m0_res_s};
                end else if (5'(i) == m1_op_s) begin
                    val_r[i] <= {32'd0, m1_res_s};
                end else if (5'(i) == a_op_s) begin
                    val_r[i] <= a_res_s;
                end
            end
        end
    end

    // Registered status and results; a28 is taken straight from the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            out_27_r <= 64'd0;
            out_28_r <= 64'd0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= finish_s;
            if (finish_s) begin
                out_27_r <= val_r[27];
                out_28_r <= a_res_s;
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.out_27 = out_27_r;
    assign bus.out_28 = out_28_r;

endmodule
